// File: rtl/token_divider.sv
// Multi-channel token rate reducer: each channel passes one of every div_q tokens.
// The config is shared by all channels; each lane keeps its own group counter.

module token_divider_lane #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             flush,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   input  logic             first,
   output logic             b,
   output logic             pending
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] last;
   logic             mute, at_first, at_last;

   always_comb begin
      last     = div - DIV_W'(1);
      mute     = (div == '0);
      at_first = (cnt_q == '0);
      at_last  = (cnt_q == last);
      // With div == 1, last is 0, so every token is both first and last and passes.
      b        = rst_n && a && !mute && (first ? at_first : at_last);

      cnt_d = cnt_q;
      if (a && !mute)
         cnt_d = at_last ? '0 : cnt_q + DIV_W'(1);
      if (mute || flush || clr)
         cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign pending = (cnt_q != '0);
endmodule

module token_divider #(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] a,
   input  logic                cfg_load,
   input  logic [DIV_W-1:0]    cfg_div,
   input  logic                cfg_first,
   input  logic [CHANNELS-1:0] flush,
   output logic [CHANNELS-1:0] b,
   output logic [CHANNELS-1:0] pending
);
   logic [DIV_W-1:0] div_q, div_d;
   logic             first_q, first_d;

   always_comb begin
      div_d   = div_q;
      first_d = first_q;
      if (cfg_load) begin
         div_d   = cfg_div;
         first_d = cfg_first;
      end
   end

   // Reset default is a plain halver emitting on the second token.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= DIV_W'(2);
         first_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         first_q <= first_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      token_divider_lane #(.DIV_W(DIV_W)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .a       (a[i]),
         .flush   (flush[i]),
         .clr     (cfg_load),
         .div     (div_q),
         .first   (first_q),
         .b       (b[i]),
         .pending (pending[i])
      );
   end
endmodule

// File: tb/tb_token_divider.sv
// Directed bench for token_divider: hand-computed token patterns per channel,
// config reload, flush and asynchronous reset behaviour.

module tb_token_divider;
   localparam int CH = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] a;
   logic          cfg_load;
   logic [DW-1:0] cfg_div;
   logic          cfg_first;
   logic [CH-1:0] flush;
   logic [CH-1:0] b;
   logic [CH-1:0] pending;

   int checks = 0;
   int errors = 0;

   token_divider #(.CHANNELS(CH), .DIV_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .cfg_load  (cfg_load),
      .cfg_div   (cfg_div),
      .cfg_first (cfg_first),
      .flush     (flush),
      .b         (b),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 with inputs already driven: check b mid-cycle, then advance.
   task automatic cyc(input string tag, input logic [CH-1:0] exp_b);
      #3;
      chk(tag, b, exp_b);
      @(posedge clk);
      #1;
      a        = '0;
      flush    = '0;
      cfg_load = 1'b0;
   endtask

   task automatic load(input logic [DW-1:0] dv, input logic fs);
      cfg_load  = 1'b1;
      cfg_div   = dv;
      cfg_first = fs;
      cyc("load_b", '0);
   endtask

   initial begin
      logic [15:0] av, bv;
      logic [5:0]  a6, b6;
      logic        par;

      rst_n = 1'b0; a = '1; flush = '0; cfg_load = 1'b0; cfg_div = '0; cfg_first = 1'b0;
      #12;
      chk("reset_b", b, 4'b0000);
      chk("reset_pending", pending, 4'b0000);
      a = '0;
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      // Default halving on ch0.
      av = 16'b1100111010001111;
      bv = 16'b0100010010000101;
      par = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         a = {3'b000, av[i]};
         cyc("halve_b", {3'b000, bv[i]});
         if (av[i]) par = ~par;
         chk("halve_pending", pending, {3'b000, par});
      end

      // div=3 on ch1, last then first.
      load(4'd3, 1'b0);
      a6 = 6'b111111; b6 = 6'b001001;
      for (int i = 5; i >= 0; i--) begin
         a = {2'b00, a6[i], 1'b0};
         cyc("div3_last_b", {2'b00, b6[i], 1'b0});
      end
      load(4'd3, 1'b1);
      b6 = 6'b100100;
      for (int i = 5; i >= 0; i--) begin
         a = {2'b00, a6[i], 1'b0};
         cyc("div3_first_b", {2'b00, b6[i], 1'b0});
      end

      // Pass-through and mute.
      load(4'd1, 1'b0);
      a = 4'b1011; cyc("div1_b0", 4'b1011);
      a = 4'b0110; cyc("div1_b1", 4'b0110);
      chk("div1_pending", pending, 4'b0000);
      load(4'd0, 1'b0);
      a = 4'b1111; cyc("mute_b0", 4'b0000);
      chk("mute_pending0", pending, 4'b0000);
      a = 4'b0101; cyc("mute_b1", 4'b0000);
      a = 4'b1010; cyc("mute_b2", 4'b0000);
      chk("mute_pending1", pending, 4'b0000);

      // Reload mid-group on ch2 discards the partial count.
      load(4'd4, 1'b0);
      a = 4'b0100; cyc("div4_b0", 4'b0000);
      a = 4'b0100; cyc("div4_b1", 4'b0000);
      chk("div4_pending", pending, 4'b0100);
      cfg_load = 1'b1; cfg_div = 4'd4; cfg_first = 1'b0; a = 4'b0100;
      cyc("reload_b", 4'b0000);
      chk("reload_pending", pending, 4'b0000);
      a = 4'b0100; cyc("regroup_b0", 4'b0000);
      a = 4'b0100; cyc("regroup_b1", 4'b0000);
      a = 4'b0100; cyc("regroup_b2", 4'b0000);
      chk("regroup_pending", pending, 4'b0100);
      a = 4'b0100; cyc("regroup_b3", 4'b0100);
      chk("regroup_pending_end", pending, 4'b0000);

      // Flush on ch3.
      load(4'd3, 1'b0);
      a = 4'b1000; cyc("fl_b0", 4'b0000);
      a = 4'b1000; cyc("fl_b1", 4'b0000);
      a = 4'b1000; flush = 4'b1000; cyc("fl_tok_b", 4'b1000);
      chk("fl_tok_pending", pending, 4'b0000);
      a = 4'b1000; cyc("fl_b2", 4'b0000);
      chk("fl_one_pending", pending, 4'b1000);
      flush = 4'b1000; cyc("fl_idle_b", 4'b0000);
      chk("fl_idle_pending", pending, 4'b0000);
      a = 4'b1000; cyc("fl_b3", 4'b0000);
      a = 4'b1000; cyc("fl_b4", 4'b0000);
      a = 4'b1000; cyc("fl_b5", 4'b1000);

      // Async reset mid-group with div=5.
      load(4'd5, 1'b0);
      for (int i = 0; i < 4; i++) begin
         a = 4'b0001; cyc("rst_pre_b", 4'b0000);
      end
      chk("rst_pre_pending", pending, 4'b0001);
      a = 4'b0001;
      #2;
      chk("rst_pre_edge_b", b, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("rst_async_b", b, 4'b0000);
      chk("rst_async_pending", pending, 4'b0000);
      a = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      a = 4'b0001; cyc("post_rst_b0", 4'b0000);
      a = 4'b0001; cyc("post_rst_b1", 4'b0001);
      chk("post_rst_pending", pending, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
